// File: rtl/axis_sgdma_rr_arbiter_pkg.sv
// Shared definitions for the scatter-gather DMA round-robin arbiter:
// FSM encoding, status word layout and the status word builder.
package axis_sgdma_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_DATA   = 2'd2
    } arb_state_e;

    // Tag placed in status word 0; the source ID sits in its low nibble.
    localparam logic [31:0] STATUS_MAGIC = 32'h5000_0000;
    localparam int          SRC_ID_LSB   = 0;
    localparam int          SRC_ID_MSB   = 3;

    // Per-source packet sequence counter width.
    localparam int          SEQ_W        = 16;

    // Status word index width; covers up to eight status words.
    localparam int          WIDX_W       = 3;

    // Build one status word: word 0 carries magic + source ID, word 1 the
    // sequence number, every later word is zero.
    function automatic logic [31:0] status_word(
        input logic [WIDX_W-1:0] widx,
        input logic [3:0]        src_id,
        input logic [SEQ_W-1:0]  seq
    );
        logic [31:0] word;
        word = 32'h0;
        if (widx == WIDX_W'(0)) begin
            word                         = STATUS_MAGIC;
            word[SRC_ID_MSB:SRC_ID_LSB]  = src_id;
        end else if (widx == WIDX_W'(1)) begin
            word = {16'h0000, seq};
        end
        return word;
    endfunction

endpackage

// File: rtl/axis_sgdma_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: returns the first asserted
// request at or after the pointer, wrapping past the highest index.
module axis_sgdma_rr_arbiter_rr_pick #(
    parameter int N_SRC = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan offsets 0..N_SRC-1 from the pointer; first hit wins.
    always_comb begin
        int cand;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = (int'(ptr) + k) % N_SRC;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_sgdma_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one SG-DMA S2MM channel.
// Each granted packet is preceded by a fixed-length status sequence tagged
// with source ID and per-source sequence number; the packet itself is then
// passed through combinationally until tlast.
module axis_sgdma_rr_arbiter
    import axis_sgdma_rr_arbiter_pkg::*;
#(
    parameter int N_SRC              = 2,
    parameter int DATA_TDATA_WIDTH   = 64,
    parameter int STATUS_TDATA_WIDTH = 32,
    parameter int STATUS_WORDS       = 5
) (
    input  logic                                clk,
    input  logic                                arstn,

    input  logic [N_SRC*DATA_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_SRC*DATA_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]                    s_axis_tvalid,
    input  logic [N_SRC-1:0]                    s_axis_tlast,
    output logic [N_SRC-1:0]                    s_axis_tready,

    output logic [DATA_TDATA_WIDTH-1:0]         data_tdata,
    output logic [DATA_TDATA_WIDTH/8-1:0]       data_tkeep,
    output logic                                data_tvalid,
    output logic                                data_tlast,
    input  logic                                data_tready,

    output logic [STATUS_TDATA_WIDTH-1:0]       status_tdata,
    output logic [3:0]                          status_tkeep,
    output logic                                status_tvalid,
    output logic                                status_tlast,
    input  logic                                status_tready,

    output logic [N_SRC-1:0]                    grant,
    output logic                                busy
);

    localparam int                IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int                KEEP_W    = DATA_TDATA_WIDTH / 8;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(STATUS_WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SRC - 1);

    arb_state_e                   state_q, state_d;
    logic [IDX_W-1:0]             gnt_idx_q, gnt_idx_d;
    logic [WIDX_W-1:0]            widx_q, widx_d;
    logic [IDX_W-1:0]             ptr_q, ptr_d;
    logic [N_SRC-1:0][SEQ_W-1:0]  seq_q, seq_d;

    logic [IDX_W-1:0]             pick_idx;
    logic                         pick_found;

    logic                         sel_valid;
    logic                         sel_last;
    logic [DATA_TDATA_WIDTH-1:0]  sel_data;
    logic [KEEP_W-1:0]            sel_keep;
    logic [SEQ_W-1:0]             sel_seq;

    axis_sgdma_rr_arbiter_rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Mux the granted source's stream and sequence counter.
    always_comb begin
        sel_valid = s_axis_tvalid[gnt_idx_q];
        sel_last  = s_axis_tlast[gnt_idx_q];
        sel_data  = s_axis_tdata[gnt_idx_q*DATA_TDATA_WIDTH +: DATA_TDATA_WIDTH];
        sel_keep  = s_axis_tkeep[gnt_idx_q*KEEP_W +: KEEP_W];
        sel_seq   = seq_q[gnt_idx_q];
    end

    // Next-state logic: grant in IDLE, walk status words, then wait for tlast.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        widx_d    = widx_q;
        ptr_d     = ptr_q;
        seq_d     = seq_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_idx_d = pick_idx;
                    widx_d    = '0;
                    state_d   = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (status_tready) begin
                    if (widx_q == WIDX_LAST) begin
                        widx_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        widx_d = widx_q + WIDX_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sel_valid && data_tready && sel_last) begin
                    seq_d[gnt_idx_q] = sel_seq + SEQ_W'(1);
                    ptr_d            = (gnt_idx_q == IDX_LAST) ? '0
                                                               : gnt_idx_q + IDX_W'(1);
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; status side depends on registers only, data side is a
    // zero-latency pass-through of the granted source.
    always_comb begin
        s_axis_tready = '0;
        data_tdata    = '0;
        data_tkeep    = '0;
        data_tvalid   = 1'b0;
        data_tlast    = 1'b0;
        status_tdata  = '0;
        status_tkeep  = 4'hF;
        status_tvalid = 1'b0;
        status_tlast  = 1'b0;
        grant         = '0;
        busy          = 1'b0;
        case (state_q)
            ST_STATUS: begin
                status_tvalid    = 1'b1;
                status_tlast     = (widx_q == WIDX_LAST);
                status_tdata     = STATUS_TDATA_WIDTH'(status_word(widx_q, 4'(gnt_idx_q), sel_seq));
                grant[gnt_idx_q] = 1'b1;
                busy             = 1'b1;
            end
            ST_DATA: begin
                data_tdata               = sel_data;
                data_tkeep               = sel_keep;
                data_tvalid              = sel_valid;
                data_tlast               = sel_last;
                s_axis_tready[gnt_idx_q] = data_tready;
                grant[gnt_idx_q]         = 1'b1;
                busy                     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            widx_q    <= '0;
            ptr_q     <= '0;
            seq_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            widx_q    <= widx_d;
            ptr_q     <= ptr_d;
            seq_q     <= seq_d;
        end
    end

endmodule

// File: tb/tb_axis_sgdma_rr_arbiter.sv
// Scoreboard bench for axis_sgdma_rr_arbiter with two sources.
module tb_axis_sgdma_rr_arbiter;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int KW = 8;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic [N*W-1:0]    s_axis_tdata = '0;
    logic [N*KW-1:0]   s_axis_tkeep = '0;
    logic [N-1:0]      s_axis_tvalid = '0;
    logic [N-1:0]      s_axis_tlast = '0;
    logic [N-1:0]      s_axis_tready;
    logic [W-1:0]      data_tdata;
    logic [KW-1:0]     data_tkeep;
    logic              data_tvalid;
    logic              data_tlast;
    logic              data_tready = 1'b1;
    logic [31:0]       status_tdata;
    logic [3:0]        status_tkeep;
    logic              status_tvalid;
    logic              status_tlast;
    logic              status_tready = 1'b1;
    logic [N-1:0]      grant;
    logic              busy;

    axis_sgdma_rr_arbiter #(
        .N_SRC              (N),
        .DATA_TDATA_WIDTH   (W),
        .STATUS_TDATA_WIDTH (32),
        .STATUS_WORDS       (SW)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .data_tdata    (data_tdata),
        .data_tkeep    (data_tkeep),
        .data_tvalid   (data_tvalid),
        .data_tlast    (data_tlast),
        .data_tready   (data_tready),
        .status_tdata  (status_tdata),
        .status_tkeep  (status_tkeep),
        .status_tvalid (status_tvalid),
        .status_tlast  (status_tlast),
        .status_tready (status_tready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  src;
        logic [15:0] seq;
    } pkt_t;

    // beat layout: {tlast, tkeep[7:0], tdata[63:0]}
    logic [72:0] src_q    [N][$];
    logic [72:0] exp_data [N][$];
    pkt_t        exp_pkt  [$];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_seq [N];
    logic [N-1:0] hold = '0;
    logic [N-1:0] src_fire = '0;
    bit          rand_sts = 1'b0;
    int          dstall = 0;

    int          mon_widx = 0;
    int          mon_beats = 0;
    int          mon_src = 0;
    logic [15:0] mon_seq = '0;
    bit          sts_stalled = 1'b0;
    logic [32:0] sts_prev = '0;

    // Source and sink driver: applies pops/holds/readies just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                logic [72:0] b;
                if (src_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                b = (src_q[i].size() > 0) ? src_q[i][0] : 73'h0;
                s_axis_tvalid[i]       = (src_q[i].size() > 0) && !hold[i];
                s_axis_tdata[i*W +: W] = b[63:0];
                s_axis_tkeep[i*KW +: KW] = b[71:64];
                s_axis_tlast[i]        = b[72];
            end
            status_tready = rand_sts ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dstall > 0) begin
                data_tready = 1'b0;
                dstall--;
            end else begin
                data_tready = 1'b1;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!arstn) begin
                src_fire    = '0;
                sts_stalled = 1'b0;
            end else begin
                logic [N-1:0] exp_gnt;
                logic [N-1:0] exp_rdy;
                logic [31:0]  exp_word;
                src_fire = s_axis_tvalid & s_axis_tready;
                exp_gnt  = '0;
                exp_gnt[mon_src] = 1'b1;
                if (sts_stalled && status_tvalid) begin
                    n_cmp++;
                    if ({status_tlast, status_tdata} !== sts_prev) begin
                        n_err++;
                        $display("FAIL status_hold: got %h required %h", {status_tlast, status_tdata}, sts_prev);
                    end
                end
                if (status_tvalid) begin
                    n_cmp++;
                    if (s_axis_tready !== '0) begin
                        n_err++;
                        $display("FAIL ready_in_status: got %b required 0", s_axis_tready);
                    end
                    if (status_tready) begin
                        sts_stalled = 1'b0;
                        if (mon_widx == 0) begin
                            mon_beats = 0;
                            if (exp_pkt.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL unexpected_packet: status word %h with no packet expected", status_tdata);
                            end else begin
                                pkt_t p;
                                p = exp_pkt.pop_front();
                                mon_src = int'(p.src);
                                mon_seq = p.seq;
                            end
                            exp_gnt = '0;
                            exp_gnt[mon_src] = 1'b1;
                        end
                        exp_word = 32'h0;
                        if (mon_widx == 0) exp_word = 32'h5000_0000 | 32'(mon_src);
                        if (mon_widx == 1) exp_word = {16'h0, mon_seq};
                        n_cmp++;
                        if ({status_tlast, status_tdata, grant} !== {(mon_widx == SW-1), exp_word, exp_gnt}) begin
                            n_err++;
                            $display("FAIL status_word%0d: got last=%b data=%h grant=%b required last=%b data=%h grant=%b",
                                     mon_widx, status_tlast, status_tdata, grant, (mon_widx == SW-1), exp_word, exp_gnt);
                        end
                        mon_widx = (mon_widx == SW-1) ? 0 : mon_widx + 1;
                    end else begin
                        sts_stalled = 1'b1;
                        sts_prev    = {status_tlast, status_tdata};
                    end
                end else begin
                    sts_stalled = 1'b0;
                end
                if (busy && !status_tvalid) begin
                    exp_rdy = '0;
                    if (data_tready) exp_rdy[mon_src] = 1'b1;
                    n_cmp++;
                    if ({s_axis_tready, grant} !== {exp_rdy, exp_gnt}) begin
                        n_err++;
                        $display("FAIL ready_mirror: got ready=%b grant=%b required ready=%b grant=%b",
                                 s_axis_tready, grant, exp_rdy, exp_gnt);
                    end
                    if (data_tvalid && data_tready) begin
                        n_cmp++;
                        if (exp_data[mon_src].size() == 0) begin
                            n_err++;
                            $display("FAIL extra_beat: got %h with none expected", data_tdata);
                        end else begin
                            logic [72:0] eb;
                            eb = exp_data[mon_src].pop_front();
                            if ({data_tlast, data_tkeep, data_tdata} !== eb) begin
                                n_err++;
                                $display("FAIL data_beat%0d: got %h required %h", mon_beats,
                                         {data_tlast, data_tkeep, data_tdata}, eb);
                            end
                        end
                        mon_beats++;
                    end
                end else if (!busy) begin
                    n_cmp++;
                    if ({s_axis_tready, grant} !== '0) begin
                        n_err++;
                        $display("FAIL idle_outputs: got ready=%b grant=%b required 0", s_axis_tready, grant);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_pkt(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            logic [72:0] beat;
            logic [7:0]  keep;
            keep = (b == len-1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            beat = {(b == len-1), keep, $urandom, $urandom};
            src_q[src].push_back(beat);
            exp_data[src].push_back(beat);
        end
        exp_pkt.push_back('{src: 2'(src), seq: model_seq[src]});
        model_seq[src] = model_seq[src] + 16'd1;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (src_q[0].size() == 0 && src_q[1].size() == 0 &&
                exp_data[0].size() == 0 && exp_data[1].size() == 0 &&
                exp_pkt.size() == 0 && !busy)
                return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s_drain: got pending pkts=%0d beats=%0d/%0d required all drained",
                 name, exp_pkt.size(), exp_data[0].size(), exp_data[1].size());
    endtask

    task automatic wait_beats(input int nb, input string name);
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #3;
            if (busy && !status_tvalid && mon_beats >= nb) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s_beat_wait: got %0d beats required %0d", name, mon_beats, nb);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({status_tvalid, status_tlast, data_tvalid, data_tlast, s_axis_tready, grant, busy} !== 9'h0 ||
            status_tkeep !== 4'hF) begin
            n_err++;
            $display("FAIL reset_state: got %b keep=%h required 0 keep=f",
                     {status_tvalid, status_tlast, data_tvalid, data_tlast, s_axis_tready, grant, busy}, status_tkeep);
        end
        #1;
        arstn = 1'b1;
    endtask

    task automatic test_single_src1();
        int cnt;
        push_pkt(1, 4);
        @(posedge clk);
        #2;
        @(negedge clk);
        n_cmp++;
        if ({busy, status_tvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL single_req_cycle: got busy=%b svalid=%b required 0 0", busy, status_tvalid);
        end
        @(negedge clk);
        n_cmp++;
        if ({status_tvalid, grant, status_tdata} !== {1'b1, 2'b10, 32'h5000_0001}) begin
            n_err++;
            $display("FAIL single_first_status: got v=%b g=%b d=%h required v=1 g=10 d=50000001",
                     status_tvalid, grant, status_tdata);
        end
        cnt = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!status_tvalid) break;
            cnt++;
        end
        n_cmp++;
        if (cnt !== SW || data_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL single_status_len: got %0d cycles dvalid=%b required %0d cycles dvalid=1",
                     cnt, data_tvalid, SW);
        end
        wait_drain("single");
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, 2 + k);
            push_pkt(1, 3);
        end
        wait_drain("alternate");
    endtask

    task automatic test_stall();
        rand_sts = 1'b1;
        push_pkt(0, 8);
        push_pkt(1, 3);
        wait_beats(3, "stall");
        dstall = 3;
        wait_drain("stall");
        rand_sts = 1'b0;
    endtask

    task automatic test_seq_wrap();
        force dut.seq_q = {model_seq[1], 16'hFFFF};
        model_seq[0] = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_q;
        @(negedge clk);
        #1;
        push_pkt(0, 2);
        wait_drain("wrap_a");
        push_pkt(0, 3);
        wait_drain("wrap_b");
    endtask

    task automatic test_src_drop();
        bit seen;
        push_pkt(0, 6);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (grant === 2'b01) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL drop_grant0: got grant=%b required 01", grant);
        end
        push_pkt(1, 3);
        wait_beats(2, "drop");
        hold[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #3;
            n_cmp++;
            if (grant !== 2'b01) begin
                n_err++;
                $display("FAIL drop_hold_grant: got grant=%b required 01", grant);
            end
        end
        hold[0] = 1'b0;
        wait_drain("drop");
    endtask

    task automatic test_reset_mid();
        push_pkt(0, 6);
        wait_beats(2, "rstmid");
        arstn = 1'b0;
        #1;
        n_cmp++;
        if ({status_tvalid, status_tlast, data_tvalid, data_tlast, s_axis_tready, grant, busy} !== 9'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b required 0",
                     {status_tvalid, status_tlast, data_tvalid, data_tlast, s_axis_tready, grant, busy});
        end
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_data[i].delete();
            model_seq[i] = 16'h0;
        end
        exp_pkt.delete();
        hold      = '0;
        dstall    = 0;
        mon_widx  = 0;
        mon_beats = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({status_tvalid, data_tvalid, s_axis_tready, grant, busy} !== 7'h0) begin
            n_err++;
            $display("FAIL reset_hold_outputs: got %b required 0",
                     {status_tvalid, data_tvalid, s_axis_tready, grant, busy});
        end
        #1;
        arstn = 1'b1;
        push_pkt(0, 2);
        push_pkt(1, 2);
        wait_drain("after_reset");
    endtask

    initial begin
        model_seq[0] = 16'h0;
        model_seq[1] = 16'h0;
        test_reset();
        test_single_src1();
        test_alternate();
        test_stall();
        test_seq_wrap();
        test_src_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_sgdma_rr_arbiter.md
# axis_sgdma_rr_arbiter

Packet-granular round-robin arbiter that shares one scatter-gather DMA S2MM channel (data stream plus status/app stream) between up to four AXI-Stream router outputs. For each granted packet it first emits a fixed-length status word sequence tagged with source ID and a per-source sequence number, then forwards the source's packet unmodified until `tlast`. Sits between the AXI Stream Router outputs and the DMA S2MM data/status ports.

## Interface
- `N_SRC`, 2: number of requesting sources, 1..4
- `DATA_TDATA_WIDTH`, 64: data stream width, multiple of 8
- `STATUS_TDATA_WIDTH`, 32: status stream width, fixed at 32
- `STATUS_WORDS`, 5: status words per packet, 2..8
- `clk`  in  1  single clock, all logic on rising edge
- `arstn`  in  1  reset, asynchronous assert, active-low
- `s_axis_tdata`  in  N_SRC*DATA_TDATA_WIDTH  source data, source i at slice i
- `s_axis_tkeep`  in  N_SRC*DATA_TDATA_WIDTH/8  source byte enables
- `s_axis_tvalid`  in  N_SRC  per-source valid
- `s_axis_tlast`  in  N_SRC  per-source end of packet
- `s_axis_tready`  out  N_SRC  per-source ready
- `data_tdata`, `data_tkeep`, `data_tvalid`, `data_tlast`  out  width-matched  DMA S2MM data
- `data_tready`  in  1  DMA data ready
- `status_tdata`  out  32  DMA status/app word
- `status_tkeep`  out  4  constant 4'hF
- `status_tvalid`, `status_tlast`  out  1  DMA status handshake
- `status_tready`  in  1  DMA status ready
- `grant`  out  N_SRC  one-hot current owner, 0 in IDLE
- `busy`  out  1  high in STATUS or DATA

## Operation
- States: IDLE, STATUS, DATA.
- IDLE: if any `s_axis_tvalid` high, grant first requester at or after round-robin pointer `ptr` (wrapping), latch `gnt_idx`, go STATUS. Otherwise stay.
- STATUS: `status_tvalid`=1; word index `widx` starts at 0, increments on each status handshake. Word 0 = 32'h5000_0000 | gnt_idx in bits [3:0]; word 1 = {16'h0, seq[gnt_idx]}; words 2..STATUS_WORDS-1 = 0. `status_tlast`=1 when `widx`==STATUS_WORDS-1; handshake on that word moves to DATA.
- DATA: `data_*` = selected source slice; `data_tvalid` = `s_axis_tvalid[gnt_idx]`; `s_axis_tready[gnt_idx]` = `data_tready`; all other `s_axis_tready` = 0. Handshake with `tlast`: `seq[gnt_idx]` += 1 (16-bit, wraps FFFF->0000), `ptr` <= (gnt_idx+1) mod N_SRC, go IDLE.
- `s_axis_tready` is 0 for every source outside DATA; no source data is consumed during status emission.
- A source dropping `tvalid` in STATUS or DATA does not lose its grant; the arbiter waits.
- Reset (any time, including mid-packet): state IDLE, `ptr`=0, `widx`=0, all `seq`=0; all `tvalid`, `tlast`, `s_axis_tready`, `grant`, `busy` = 0. Partially transferred packets are abandoned.

## Timing
- State, `gnt_idx`, `widx`, `ptr`, `seq` are registered; `status_tdata/tvalid/tlast` decode from registers only, with no combinational path from any `tready`.
- The data path is combinational pass-through in DATA: zero latency, one beat per cycle at full throughput.
- Request in IDLE at cycle t -> first status word valid at t+1. With ready always high: STATUS lasts STATUS_WORDS cycles, and one IDLE cycle separates consecutive packets.
- `status_tready` low holds the current word stable. `data_tready` low stalls the source via `s_axis_tready`.
- Simultaneous requests resolve strictly by `ptr` order. A lone requester is regranted every packet.

## Structure
- Shared package holds the state encoding, STATUS_MAGIC = 32'h5000_0000, the SRC_ID field position [3:0], and the SEQ width of 16.
- One sub-module is natural: `rr_pick`, a combinational round-robin priority encoder (request vector and pointer in, index and found flag out).

## Test plan
- N_SRC=2, one 4-beat packet on source 1, all readies high -> status words 5000_0001, 0000_0000, 0, 0, 0 (tlast on fifth), then 4 data beats with tlast on beat 4, `grant`=2'b10 throughout.
- Both sources continuously valid, 3 packets each -> grant order 0,1,0,1,0,1; word 1 sequence numbers 0,0,1,1,2,2.
- `status_tready` toggled 1/0 pseudo-randomly, plus `data_tready` low for 3 cycles mid-packet -> status words unchanged while stalled, no beat lost or duplicated, `s_axis_tready[g]` mirrors `data_tready`.
- Force `seq[0]`=16'hFFFF, send one packet -> word 1 = 0000_FFFF, next packet word 1 = 0000_0000.
- Assert `arstn` low in DATA after 2 of 6 beats -> all valids, readies, `grant` and `busy` at 0 immediately. After release, the next request is served starting from source 0 with seq 0.
- Source 0 drops `tvalid` for 5 cycles mid-packet while source 1 is valid -> grant stays on source 0 until its tlast, then source 1 is granted.
